hex7seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for an NDIG-digit common-anode 7-seg display.

---
 rtl/hex7seg_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_hex7seg_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hex7seg_scan_ctrl.sv
// Time-multiplexed NDIG-digit common-anode 7-seg scan controller with frame-atomic loads.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module hex7seg_scan_ctrl #(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LOAD,
  input  logic [4*NDIG-1:0] VALUE,
  input  logic [NDIG-1:0]   DP_IN,
  output logic [7:0]        HEX,
  output logic [NDIG-1:0]   DIG_SEL,
  output logic              FRAME_DONE,
  output logic              PENDING
);

  localparam int unsigned      CNT_W    = $clog2(SCAN_DIV);
  localparam int unsigned      IDX_W    = $clog2(NDIG);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [4*NDIG-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NDIG-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic              pend_flag_q, pend_flag_d;
  logic [7:0]        hex_q, hex_d;
  logic [NDIG-1:0]   dig_sel_q, dig_sel_d;
  logic              frame_done_q, frame_done_d;

  logic              slot_end, last_dig, boundary;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic [7:0]        digit_hex;
`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0]  top_nz;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h58;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end    = (cnt_q == CNT_LAST);
    last_dig    = (idx_q == IDX_LAST);
    boundary    = slot_end && last_dig;
    cnt_d       = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    if (slot_end) idx_d = last_dig ? '0 : idx_q + IDX_W'(1);
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    if (boundary && pend_flag_q) begin
      act_val_d   = pend_val_q;
      act_dp_d    = pend_dp_q;
      pend_flag_d = 1'b0;
    end
    // A load on the boundary cycle refills pending after the old value has been promoted.
    if (LOAD) begin
      pend_val_d  = VALUE;
      pend_dp_d   = DP_IN;
      pend_flag_d = 1'b1;
    end
  end

  // Outputs are decoded from next-state so the registered display lines up with cnt/idx.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    hex_d     = 8'hFF;
    dig_sel_d = '1;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (idx_d == IDX_W'(k)) begin
        cur_nib = act_val_d[4*k +: 4];
        cur_dp  = act_dp_d[k];
      end
    end
    digit_hex = {~cur_dp, seg7(cur_nib)};
`ifdef LEADING_ZERO_BLANK_EN
    top_nz = '0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (act_val_d[4*k +: 4] != 4'h0) top_nz = IDX_W'(k);
    end
    if (idx_d > top_nz) digit_hex = cur_dp ? 8'h7F : 8'hFF;
`endif
    if (cnt_d != '0) begin
      hex_d = digit_hex;
      for (int unsigned k = 0; k < NDIG; k++) begin
        dig_sel_d[k] = (idx_d != IDX_W'(k));
      end
    end
    frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      hex_q        <= 8'hFF;
      dig_sel_q    <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      hex_q        <= hex_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign HEX        = hex_q;
  assign DIG_SEL    = dig_sel_q;
  assign FRAME_DONE = frame_done_q;
  assign PENDING    = pend_flag_q;

endmodule

// File: tb/tb_hex7seg_scan_ctrl.sv
// Randomized self-checking bench for hex7seg_scan_ctrl (NDIG=4, SCAN_DIV=4).
// Honours LEADING_ZERO_BLANK_EN in both the reference model and the literal expectations.
module tb_hex7seg_scan_ctrl;
  localparam int unsigned N = 4;
  localparam int unsigned S = 4;
  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] VALUE = '0;
  logic [3:0]  DP_IN = '0;
  logic [7:0]  HEX;
  logic [3:0]  DIG_SEL;
  logic        FRAME_DONE;
  logic        PENDING;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  always #5 CLK = ~CLK;

  hex7seg_scan_ctrl #(.NDIG(N), .SCAN_DIV(S)) dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .VALUE(VALUE), .DP_IN(DP_IN),
    .HEX(HEX), .DIG_SEL(DIG_SEL), .FRAME_DONE(FRAME_DONE), .PENDING(PENDING)
  );

  // Reference model: t = clock edges since reset; slot/digit follow by division.
  int unsigned t;
  logic [15:0] m_act_v, m_pend_v;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_pflag;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      t = 0; m_act_v = '0; m_pend_v = '0; m_act_dp = '0; m_pend_dp = '0; m_pflag = 1'b0;
    end else begin
      if ((t % S) == S - 1 && ((t / S) % N) == N - 1 && m_pflag) begin
        m_act_v = m_pend_v; m_act_dp = m_pend_dp; m_pflag = 1'b0;
      end
      if (LOAD) begin
        m_pend_v = VALUE; m_pend_dp = DP_IN; m_pflag = 1'b1;
      end
      t++;
    end
  end

  function automatic logic [7:0] digit_hex(int unsigned k, logic [15:0] v, logic [3:0] dp);
    logic [15:0] sh;
    logic [7:0]  h;
    int unsigned top;
    sh = v >> (4 * k);
    h = SEG[sh[3:0]];
    h[7] = ~dp[k];
    if (BLANK) begin
      top = 0;
      for (int unsigned j = 0; j < N; j++) begin
        sh = v >> (4 * j);
        if (sh[3:0] != 4'h0) top = j;
      end
      if (k > top) h = dp[k] ? 8'h7F : 8'hFF;
    end
    return h;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (check_en) begin
      int unsigned cnt, idx;
      logic [7:0] eh;
      logic [3:0] es;
      cnt = t % S;
      idx = (t / S) % N;
      if (cnt == 0) begin
        eh = 8'hFF; es = 4'hF;
      end else begin
        eh = digit_hex(idx, m_act_v, m_act_dp);
        es = ~(4'b0001 << idx);
      end
      chk("hex", 16'(HEX), 16'(eh));
      chk("dig_sel", 16'(DIG_SEL), 16'(es));
      chk("frame_done", 16'(FRAME_DONE), 16'(cnt == S - 1 && idx == N - 1));
      chk("pending", 16'(PENDING), 16'(m_pflag));
    end
  end

  task automatic wait_digit(input int unsigned k, input logic [7:0] exp_hex, input string name);
    bit found = 1'b0;
    logic [3:0] sel;
    sel = ~(4'b0001 << k);
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge CLK);
      if (DIG_SEL == sel) found = 1'b1;
    end
    #1;
    chk({name, "_seen"}, 16'(found), 16'd1);
    if (found) chk(name, 16'(HEX), 16'(exp_hex));
  endtask

  task automatic wait_frame(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge CLK);
      if (FRAME_DONE) found = 1'b1;
    end
    chk({name, "_frame_seen"}, 16'(found), 16'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    @(posedge CLK); #1;
    LOAD = 1'b1; VALUE = v; DP_IN = dp;
    @(posedge CLK); #1;
    LOAD = 1'b0;
  endtask

  initial begin
    check_en = 1'b1;
    #12;
    chk("rst_hex", 16'(HEX), 16'hFF);
    chk("rst_sel", 16'(DIG_SEL), 16'hF);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // Power-up display of zero
    wait_digit(0, 8'hC0, "t1_d0");
    wait_digit(1, BLANK ? 8'hFF : 8'hC0, "t1_d1");
    wait_digit(2, BLANK ? 8'hFF : 8'hC0, "t1_d2");
    wait_digit(3, BLANK ? 8'hFF : 8'hC0, "t1_d3");

    // Atomic load mid-frame
    do_load(16'h1234, 4'b0000);
    @(negedge CLK); #1;
    chk("t2_pending", 16'(PENDING), 16'd1);
    wait_frame("t2");
    wait_digit(0, 8'h99, "t2_d0");
    wait_digit(1, 8'hB0, "t2_d1");
    wait_digit(2, 8'hA4, "t2_d2");
    wait_digit(3, 8'hF9, "t2_d3");
    chk("t2_pending_clr", 16'(PENDING), 16'd0);

    // Load landing exactly on the boundary cycle
    do_load(16'h1111, 4'b0000);
    wait_frame("t3a");
    LOAD = 1'b1; VALUE = 16'h2222; DP_IN = 4'b0000;
    @(posedge CLK); #1;
    LOAD = 1'b0;
    for (int unsigned k = 0; k < N; k++) wait_digit(k, 8'hF9, "t3_old");
    chk("t3_pending_held", 16'(PENDING), 16'd1);
    wait_frame("t3b");
    for (int unsigned k = 0; k < N; k++) wait_digit(k, 8'hA4, "t3_new");
    chk("t3_pending_clr", 16'(PENDING), 16'd0);

    // Decimal point handling
    do_load(16'h0008, 4'b0010);
    wait_frame("t4");
    wait_digit(0, 8'h80, "t4_d0");
    wait_digit(1, BLANK ? 8'h7F : 8'h40, "t4_d1");
    wait_digit(2, BLANK ? 8'hFF : 8'hC0, "t4_d2");

    // Leading zero behaviour
    do_load(16'h0050, 4'b0000);
    wait_frame("t6");
    wait_digit(0, 8'hC0, "t6_d0");
    wait_digit(1, 8'h92, "t6_d1");
    wait_digit(2, BLANK ? 8'hFF : 8'hC0, "t6_d2");
    wait_digit(3, BLANK ? 8'hFF : 8'hC0, "t6_d3");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      LOAD  = ($urandom_range(0, 5) == 0);
      VALUE = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      DP_IN = 4'($urandom);
    end
    @(posedge CLK); #1;
    LOAD = 1'b0;

    // Asynchronous reset mid-slot with a load pending
    do_load(16'hABCD, 4'b1111);
    @(negedge CLK); #1;
    chk("t5_pending_before", 16'(PENDING), 16'd1);
    @(posedge CLK); #3;
    RST_N = 1'b0;
    #1;
    chk("t5_hex", 16'(HEX), 16'hFF);
    chk("t5_sel", 16'(DIG_SEL), 16'hF);
    chk("t5_pending", 16'(PENDING), 16'd0);
    chk("t5_frame_done", 16'(FRAME_DONE), 16'd0);
    #20;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    wait_digit(0, 8'hC0, "t5_d0");
    wait_digit(1, BLANK ? 8'hFF : 8'hC0, "t5_d1");

    @(negedge CLK);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
